// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_pkg
// Desc     : Shared types and constants for the FIFO stream drain.
//            DRAIN_PARITY_EN adds a parity bit to every buffer entry.
// Revision : 1.0  initial release
// ============================================================================
package fifo_drain_pkg;

  localparam int DRAIN_WIDTH = 16;
  localparam int BUF_DEPTH   = 2;
  localparam int OCC_W       = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W       = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [DRAIN_WIDTH-1:0] data;
    logic                   last;
`ifdef DRAIN_PARITY_EN
    logic                   parity;
`endif
  } drain_entry_t;

endpackage

`default_nettype wire

// File: rtl/fifo_stream_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_drain_if
// Desc     : Valid/ready output stream of the FIFO drain.
//            DRAIN_PARITY_EN adds the m_parity sideband.
// Revision : 1.0  initial release
// ============================================================================
import fifo_drain_pkg::*;

interface fifo_stream_drain_if #(
  parameter int WIDTH = DRAIN_WIDTH
);

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
`ifdef DRAIN_PARITY_EN
  logic             m_parity;

  modport master (output m_valid, output m_data, output m_last, output m_parity, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, input m_parity, output m_ready);
`else
  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
`endif

endinterface

`default_nettype wire

// File: rtl/drain_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : drain_skid_buf
// Desc     : 2-entry ordered buffer holding popped words until accepted.
// Revision : 1.0  initial release
// ============================================================================
import fifo_drain_pkg::*;

module drain_skid_buf #(
  parameter type entry_t = drain_entry_t
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [OCC_W-1:0] occ
);

  entry_t           r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_occ == OCC_W'(BUF_DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_pop   = pop && !w_empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign w_push  = push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  assign head = r_mem[r_rd_ptr];
  assign occ  = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_drain
// Desc     : Pops a synchronous FIFO and re-issues its words as a valid/ready
//            packet stream. DRAIN_PARITY_EN adds per-word even parity.
// Revision : 1.0  initial release
// ============================================================================
import fifo_drain_pkg::*;

module fifo_stream_drain #(
  parameter int WIDTH   = DRAIN_WIDTH,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                drain_en,
  input  logic                fifo_empty_bar,
  input  logic [WIDTH-1:0]    fifo_data_out,
  output logic                fifo_get,
  fifo_stream_drain_if.master m_if,
  output logic                idle,
  output logic [CNT_W-1:0]    words_sent
);

  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
`ifdef DRAIN_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  drain_state_t     r_state;
  drain_state_t     w_state_next;
  logic             r_inflight;
  logic [PKT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_words_sent;

  logic [OCC_W-1:0] w_occ;
  logic [OCC_W:0]   w_credit;
  logic             w_accept;
  logic             w_pkt_wrap;
  entry_t           w_push_entry;
  entry_t           w_head;

  assign w_accept   = m_if.m_valid && m_if.m_ready;
  assign w_pkt_wrap = (r_pkt_cnt == PKT_W'(PKT_LEN - 1));

  // Slots committed after this cycle: buffered plus in flight, minus the word leaving now.
  assign w_credit = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight}
                  - {{OCC_W{1'b0}}, w_accept};

  assign fifo_get = !reset && (r_state == RUN) && fifo_empty_bar
                 && (w_credit < (OCC_W + 1)'(BUF_DEPTH));

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = fifo_data_out;
    w_push_entry.last = w_pkt_wrap;
`ifdef DRAIN_PARITY_EN
    w_push_entry.parity = ^fifo_data_out;
`endif
  end

  drain_skid_buf #(
    .entry_t    (entry_t)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (r_inflight),
    .push_entry (w_push_entry),
    .pop        (w_accept),
    .head       (w_head),
    .occ        (w_occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (drain_en) w_state_next = RUN;
      RUN:  if (!drain_en) w_state_next = STOP;
      STOP: begin
        if (drain_en) begin
          w_state_next = RUN;
        end else if (!r_inflight && (w_occ == '0)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The FIFO presents a popped word one cycle after the get, so it is captured then.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight   <= 1'b0;
      r_pkt_cnt    <= '0;
      r_words_sent <= '0;
    end else begin
      r_inflight <= fifo_get;
      if (r_inflight) begin
        r_pkt_cnt <= w_pkt_wrap ? '0 : r_pkt_cnt + PKT_W'(1);
      end
      if (w_accept && (r_words_sent != {CNT_W{1'b1}})) begin
        r_words_sent <= r_words_sent + CNT_W'(1);
      end
    end
  end

  assign m_if.m_valid = (w_occ != '0);
  assign m_if.m_data  = w_head.data;
  assign m_if.m_last  = w_head.last;
`ifdef DRAIN_PARITY_EN
  assign m_if.m_parity = w_head.parity;
`endif

  assign idle       = (r_state == IDLE) && (w_occ == '0) && !r_inflight;
  assign words_sent = r_words_sent;

endmodule

`default_nettype wire
